// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared opcodes, IR field positions, branch FSM states and
//                the per-opcode flag decode for the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif

package decode_pkg;

    localparam logic [7:0] OP_NOP  = 8'hFF;
    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_ADDI = 8'h01;
    localparam logic [7:0] OP_BRZ  = 8'h20;

    localparam int c_OPCODE_LSB = 24;
    localparam int c_DEST_LSB   = 20;
    localparam int c_SRC1_LSB   = 16;
    localparam int c_SRC2_LSB   = 8;
    localparam int c_IMM_LSB    = 0;

    typedef struct packed {
        logic uses_src1;
        logic uses_src2;
        logic writes_dest;
        logic is_branch;
    } op_flags_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_BR_WAIT = 1'b1
    } br_state_t;

    // Unknown opcodes decode like NOP so they never touch the scoreboard.
    function automatic op_flags_t decode_flags(input logic [7:0] opcode);
        op_flags_t f;
        f = '0;
        case (opcode)
            OP_ADD:  begin f.uses_src1 = 1'b1; f.uses_src2 = 1'b1; f.writes_dest = 1'b1; end
            OP_ADDI: begin f.uses_src1 = 1'b1; f.writes_dest = 1'b1; end
            OP_BRZ:  begin f.uses_src1 = 1'b1; f.is_branch = 1'b1; end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard
//  Description : Per-register pending-write counters and hazard detection.
//                Build option DECODE_WB_BYPASS_EN clears a hazard on a source
//                whose last outstanding write is being written back now.
//  Revision    : 1.0  initial release
// ============================================================================

module scoreboard
    import decode_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int SB_CNT_WIDTH = 2,
    parameter int REG_W        = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_lock,
    input  logic             i_fe_valid,
    input  logic             i_uses_src1,
    input  logic             i_uses_src2,
    input  logic             i_writes_dest,
    input  logic [REG_W-1:0] i_src1,
    input  logic [REG_W-1:0] i_src2,
    input  logic [REG_W-1:0] i_dest,
    input  logic             i_issue,
    input  logic             i_wb_valid,
    input  logic [REG_W-1:0] i_wb_dest,
    output logic             o_hazard
);

    localparam logic [SB_CNT_WIDTH-1:0] c_CNT_ONE = SB_CNT_WIDTH'(1);
    localparam logic [SB_CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [SB_CNT_WIDTH-1:0] r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]     w_inc;
    logic [NUM_REGS-1:0]     w_dec;
    logic                    w_busy1;
    logic                    w_busy2;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = i_issue && i_writes_dest && (i_dest == REG_W'(i));
            w_dec[i] = i_wb_valid && (i_wb_dest == REG_W'(i));
        end
    end

    // Issue and writeback to the same register cancel; a stray writeback at
    // zero is dropped instead of wrapping.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
        end else if (i_lock) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_busy1 = (r_cnt[i_src1] != '0);
        w_busy2 = (r_cnt[i_src2] != '0);
`ifdef DECODE_WB_BYPASS_EN
        if (i_wb_valid && (i_wb_dest == i_src1) && (r_cnt[i_src1] == c_CNT_ONE)) w_busy1 = 1'b0;
        if (i_wb_valid && (i_wb_dest == i_src2) && (r_cnt[i_src2] == c_CNT_ONE)) w_busy2 = 1'b0;
`endif
    end

    assign o_hazard = i_fe_valid &&
                      ((i_uses_src1 && w_busy1) ||
                       (i_uses_src2 && w_busy2) ||
                       (i_writes_dest && (r_cnt[i_dest] == c_CNT_MAX)));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Decode stage: register file, scoreboard, branch FSM and the
//                Execute-facing output latch. Build option DECODE_WB_BYPASS_EN
//                forwards same-cycle writeback data into the operands.
//  Revision    : 1.0  initial release
// ============================================================================

module decode_stage
    import decode_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int SB_CNT_WIDTH = 2
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_LOCK,
    input  logic [`PC_WIDTH-1:0]  I_PC,
    input  logic [`IR_WIDTH-1:0]  I_IR,
    input  logic                  I_FE_Valid,
    input  logic                  I_BranchAddrSelect,
    input  logic                  I_GPUStallSignal,
    input  logic                  I_WBValid,
    input  logic [3:0]            I_WBDestReg,
    input  logic [DATA_WIDTH-1:0] I_WBData,
    output logic                  O_DepStallSignal,
    output logic                  O_BranchStallSignal,
    output logic                  O_DE_Valid,
    output logic [`PC_WIDTH-1:0]  O_PC,
    output logic [7:0]            O_Opcode,
    output logic [3:0]            O_DestReg,
    output logic [DATA_WIDTH-1:0] O_Src1Value,
    output logic [DATA_WIDTH-1:0] O_Src2Value,
    output logic [DATA_WIDTH-1:0] O_Imm
);

    logic [7:0]            w_opcode;
    logic [3:0]            w_dest;
    logic [3:0]            w_src1;
    logic [3:0]            w_src2;
    logic [DATA_WIDTH-1:0] w_imm;
    op_flags_t             w_flags;
    logic                  w_hazard;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_src1_val;
    logic [DATA_WIDTH-1:0] w_src2_val;
    br_state_t             r_state;
    br_state_t             w_state_next;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    assign w_opcode = I_IR[c_OPCODE_LSB +: 8];
    assign w_dest   = I_IR[c_DEST_LSB +: 4];
    assign w_src1   = I_IR[c_SRC1_LSB +: 4];
    assign w_src2   = I_IR[c_SRC2_LSB +: 4];
    assign w_imm    = DATA_WIDTH'(I_IR[c_IMM_LSB +: 16]);
    assign w_flags  = decode_flags(w_opcode);

    scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .SB_CNT_WIDTH (SB_CNT_WIDTH),
        .REG_W        (4)
    ) u_scoreboard (
        .clk           (I_CLOCK),
        .rst           (I_RESET),
        .i_lock        (I_LOCK),
        .i_fe_valid    (I_FE_Valid),
        .i_uses_src1   (w_flags.uses_src1),
        .i_uses_src2   (w_flags.uses_src2),
        .i_writes_dest (w_flags.writes_dest),
        .i_src1        (w_src1),
        .i_src2        (w_src2),
        .i_dest        (w_dest),
        .i_issue       (w_issue),
        .i_wb_valid    (I_WBValid),
        .i_wb_dest     (I_WBDestReg),
        .o_hazard      (w_hazard)
    );

    assign O_DepStallSignal    = I_LOCK && (w_hazard || I_GPUStallSignal);
    assign w_issue             = I_LOCK && I_FE_Valid && !O_DepStallSignal && (r_state == ST_IDLE);
    assign O_BranchStallSignal = (r_state == ST_BR_WAIT);

    always_comb begin
        w_src1_val = r_regs[w_src1];
        w_src2_val = r_regs[w_src2];
`ifdef DECODE_WB_BYPASS_EN
        if (I_WBValid && (I_WBDestReg == w_src1)) w_src1_val = I_WBData;
        if (I_WBValid && (I_WBDestReg == w_src2)) w_src2_val = I_WBData;
`endif
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (I_LOCK && I_WBValid) begin
            r_regs[I_WBDestReg] <= I_WBData;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET)     r_state <= ST_IDLE;
        else if (I_LOCK) r_state <= w_state_next;
    end

    // The instruction seen on the redirect cycle is dropped: no issue in BR_WAIT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_issue && w_flags.is_branch) w_state_next = ST_BR_WAIT;
            ST_BR_WAIT: if (I_BranchAddrSelect)          w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Bubbles only rewrite valid and opcode; the remaining fields are don't-care.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_DE_Valid  <= 1'b0;
            O_PC        <= '0;
            O_Opcode    <= OP_NOP;
            O_DestReg   <= '0;
            O_Src1Value <= '0;
            O_Src2Value <= '0;
            O_Imm       <= '0;
        end else if (I_LOCK && !I_GPUStallSignal) begin
            if (w_issue) begin
                O_DE_Valid  <= 1'b1;
                O_PC        <= I_PC;
                O_Opcode    <= w_opcode;
                O_DestReg   <= w_dest;
                O_Src1Value <= w_src1_val;
                O_Src2Value <= w_src2_val;
                O_Imm       <= w_imm;
            end else begin
                O_DE_Valid  <= 1'b0;
                O_Opcode    <= OP_NOP;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage with a reference model.
//                Honours DECODE_WB_BYPASS_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif

module tb_decode_stage;

    localparam logic [7:0] NOP = 8'hFF, ADD = 8'h00, ADDI = 8'h01, BRZ = 8'h20;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, lock, fe, brsel, gpu, wbv;
    logic [31:0] pc, ir;
    logic [3:0]  wbd;
    logic [15:0] wbdata;
    logic        dep, brstall, de_valid;
    logic [31:0] o_pc;
    logic [7:0]  o_op;
    logic [3:0]  o_dest;
    logic [15:0] o_s1, o_s2, o_imm;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_cnt [16];
    logic [15:0] m_regs [16];
    bit          m_br;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [7:0]  m_op;
    logic [3:0]  m_dest;
    logic [15:0] m_s1, m_s2, m_imm;

    decode_stage dut (
        .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_PC(pc), .I_IR(ir),
        .I_FE_Valid(fe), .I_BranchAddrSelect(brsel), .I_GPUStallSignal(gpu),
        .I_WBValid(wbv), .I_WBDestReg(wbd), .I_WBData(wbdata),
        .O_DepStallSignal(dep), .O_BranchStallSignal(brstall), .O_DE_Valid(de_valid),
        .O_PC(o_pc), .O_Opcode(o_op), .O_DestReg(o_dest),
        .O_Src1Value(o_s1), .O_Src2Value(o_s2), .O_Imm(o_imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] d, s1, s2);
        return {op, d, s1, 4'h0, s2, 8'h5A};
    endfunction

    function automatic void op_info(input logic [7:0] op, output bit u1, u2, wd, isb);
        {u1, u2, wd, isb} = 4'b0000;
        if (op == ADD)  {u1, u2, wd} = 3'b111;
        if (op == ADDI) {u1, wd} = 2'b11;
        if (op == BRZ)  {u1, isb} = 2'b11;
    endfunction

    function automatic bit pending(input logic [3:0] r);
        if (m_cnt[r] == 0) return 1'b0;
        if (BYP && wbv && wbd == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_dep();
        bit u1, u2, wd, isb, haz;
        op_info(ir[31:24], u1, u2, wd, isb);
        haz = fe && ((u1 && pending(ir[19:16])) || (u2 && pending(ir[11:8])) ||
                     (wd && m_cnt[ir[23:20]] == 3));
        return lock && (haz || gpu);
    endfunction

    task automatic model_update();
        bit u1, u2, wd, isb, iss;
        logic [15:0] v1, v2;
        if (rst) begin
            for (int r = 0; r < 16; r++) begin m_cnt[r] = 0; m_regs[r] = '0; end
            m_br = 0; m_valid = 0; m_pc = '0; m_op = NOP; m_dest = '0;
            m_s1 = '0; m_s2 = '0; m_imm = '0;
        end else if (lock) begin
            op_info(ir[31:24], u1, u2, wd, isb);
            iss = fe && !exp_dep() && !m_br;
            v1 = (BYP && wbv && wbd == ir[19:16]) ? wbdata : m_regs[ir[19:16]];
            v2 = (BYP && wbv && wbd == ir[11:8])  ? wbdata : m_regs[ir[11:8]];
            if (!gpu) begin
                if (iss) begin
                    m_valid = 1; m_pc = pc; m_op = ir[31:24]; m_dest = ir[23:20];
                    m_s1 = v1; m_s2 = v2; m_imm = ir[15:0];
                end else begin
                    m_valid = 0; m_op = NOP;
                end
            end
            for (int r = 0; r < 16; r++) begin
                bit inc, dec;
                inc = iss && wd && ir[23:20] == r;
                dec = wbv && wbd == r;
                if (inc && !dec) m_cnt[r]++;
                else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
            end
            if (wbv) m_regs[wbd] = wbdata;
            if (m_br) begin
                if (brsel) m_br = 0;
            end else if (iss && isb) begin
                m_br = 1;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic [31:0] i, input logic b = 1'b0,
                         input logic g = 1'b0, input logic wv = 1'b0,
                         input logic [3:0] wd = 4'h0, input logic [15:0] wdat = 16'h0);
        fe = f; ir = i; brsel = b; gpu = g; wbv = wv; wbd = wd; wbdata = wdat;
        pc = $urandom;
    endtask

    task automatic do_reset();
        rst = 1; lock = 1; drive(0, mk(NOP, 0, 0, 0)); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; lock = 0; drive(1, mk(ADD, 1, 2, 3)); tick(); rst = 0; lock = 1;
        drive(0, mk(NOP, 0, 0, 0)); #1;
        checks++;
        if ({de_valid, brstall, o_op, o_dest, o_pc, o_s1, o_s2, o_imm} !== {1'b0, 1'b0, 8'hFF, 4'h0, 32'h0, 48'h0}) begin
            errors++; $display("FAIL reset_state: valid=%b br=%b op=%h dest=%h pc=%h s1=%h s2=%h imm=%h expected 0,0,ff,0...", de_valid, brstall, o_op, o_dest, o_pc, o_s1, o_s2, o_imm);
        end
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL reset_dep: got %b expected 0", dep); end
    endtask

    task automatic test_issue();
        logic [31:0] spc;
        drive(1, mk(ADD, 1, 2, 3)); spc = pc; #1;
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL issue_dep: got %b expected 0", dep); end
        tick();
        checks++;
        if ({de_valid, o_op, o_dest, o_pc, o_s1, o_imm} !== {1'b1, 8'h00, 4'd1, spc, 16'h0, 16'h035A}) begin
            errors++; $display("FAIL issue_out: valid=%b op=%h dest=%h pc=%h s1=%h imm=%h expected 1,00,1,%h,0000,035a", de_valid, o_op, o_dest, o_pc, o_s1, o_imm, spc);
        end
    endtask

    task automatic test_dependency();
        drive(1, mk(ADD, 4, 1, 1)); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dep !== 1'b1) begin errors++; $display("FAIL dep_stall: got %b expected 1", dep); end
            tick();
            checks++;
            if ({de_valid, o_op} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL dep_bubble: valid=%b op=%h expected 0,ff", de_valid, o_op); end
        end
        drive(1, mk(ADD, 4, 1, 1), 0, 0, 1, 4'd1, 16'h00AA); #1;
        checks++;
        if (dep !== !BYP) begin errors++; $display("FAIL dep_wb_edge: got %b expected %b", dep, !BYP); end
        tick();
        if (!BYP) begin
            checks++;
            if (de_valid !== 1'b0) begin errors++; $display("FAIL dep_wb_bubble: valid=%b expected 0", de_valid); end
            drive(1, mk(ADD, 4, 1, 1)); #1;
            checks++;
            if (dep !== 1'b0) begin errors++; $display("FAIL dep_clear: got %b expected 0", dep); end
            tick();
        end
        checks++;
        if ({de_valid, o_dest, o_s1, o_s2} !== {1'b1, 4'd4, 16'h00AA, 16'h00AA}) begin
            errors++; $display("FAIL dep_issue: valid=%b dest=%h s1=%h s2=%h expected 1,4,00aa,00aa", de_valid, o_dest, o_s1, o_s2);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, mk(ADDI, 5, 0, 0)); tick();
            checks++;
            if (de_valid !== 1'b1) begin errors++; $display("FAIL sat_issue%0d: valid=%b expected 1", k, de_valid); end
        end
        drive(1, mk(ADDI, 5, 0, 0)); #1;
        checks++;
        if (dep !== 1'b1) begin errors++; $display("FAIL sat_full: dep=%b expected 1", dep); end
        tick();
        drive(0, mk(NOP, 0, 0, 0), 0, 0, 1, 4'd5, 16'h0011); tick();
        drive(1, mk(ADDI, 5, 0, 0), 0, 0, 1, 4'd5, 16'h0022); #1;
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL sat_cancel_dep: dep=%b expected 0", dep); end
        tick();
        drive(1, mk(ADDI, 5, 0, 0)); #1;
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL sat_refill_dep: dep=%b expected 0", dep); end
        tick();
        drive(1, mk(ADDI, 5, 0, 0)); #1;
        checks++;
        if (dep !== 1'b1) begin errors++; $display("FAIL sat_unchanged: dep=%b expected 1", dep); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, mk(BRZ, 0, 0, 0)); tick();
        checks++;
        if ({de_valid, o_op, brstall} !== {1'b1, 8'h20, 1'b1}) begin
            errors++; $display("FAIL br_issue: valid=%b op=%h br=%b expected 1,20,1", de_valid, o_op, brstall);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, mk(ADD, 6, 2, 3)); tick();
            checks++;
            if ({de_valid, o_op, brstall} !== {1'b0, 8'hFF, 1'b1}) begin
                errors++; $display("FAIL br_wait: valid=%b op=%h br=%b expected 0,ff,1", de_valid, o_op, brstall);
            end
        end
        drive(1, mk(ADD, 6, 2, 3), 1); tick();
        checks++;
        if ({de_valid, brstall} !== {1'b0, 1'b0}) begin
            errors++; $display("FAIL br_resolve: valid=%b br=%b expected 0,0", de_valid, brstall);
        end
        drive(1, mk(ADD, 7, 2, 3), 1); tick();
        checks++;
        if ({de_valid, o_dest, brstall} !== {1'b1, 4'd7, 1'b0}) begin
            errors++; $display("FAIL br_after: valid=%b dest=%h br=%b expected 1,7,0", de_valid, o_dest, brstall);
        end
    endtask

    task automatic test_gpu_stall();
        logic [31:0] spc;
        do_reset();
        drive(1, mk(ADD, 1, 2, 3)); spc = pc; tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, mk(ADD, 9, 2, 3), 0, 1); #1;
            checks++;
            if (dep !== 1'b1) begin errors++; $display("FAIL gpu_dep: dep=%b expected 1", dep); end
            tick();
            checks++;
            if ({de_valid, o_dest, o_pc} !== {1'b1, 4'd1, spc}) begin
                errors++; $display("FAIL gpu_hold: valid=%b dest=%h pc=%h expected 1,1,%h", de_valid, o_dest, o_pc, spc);
            end
        end
        drive(1, mk(ADD, 10, 9, 0)); #1;
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL gpu_no_count: dep=%b expected 0", dep); end
        tick();
        lock = 0; drive(1, mk(ADD, 11, 1, 1)); #1;
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL unlock_dep: dep=%b expected 0", dep); end
        tick();
        checks++;
        if ({de_valid, o_dest} !== {1'b1, 4'd10}) begin
            errors++; $display("FAIL unlock_hold: valid=%b dest=%h expected 1,a", de_valid, o_dest);
        end
        lock = 1;
    endtask

    task automatic test_reset_in_branch();
        do_reset();
        drive(0, mk(NOP, 0, 0, 0), 0, 0, 1, 4'd7, 16'h1234); tick();
        drive(1, mk(ADDI, 2, 0, 0)); tick();
        drive(1, mk(ADDI, 2, 0, 0)); tick();
        drive(1, mk(BRZ, 0, 0, 0)); tick();
        rst = 1; lock = 0; drive(1, mk(ADD, 3, 2, 7)); tick(); rst = 0; lock = 1;
        checks++;
        if ({brstall, de_valid, o_op, o_dest, o_pc} !== {1'b0, 1'b0, 8'hFF, 4'h0, 32'h0}) begin
            errors++; $display("FAIL rst_br_state: br=%b valid=%b op=%h dest=%h pc=%h expected 0,0,ff,0,0", brstall, de_valid, o_op, o_dest, o_pc);
        end
        drive(1, mk(ADD, 3, 2, 7)); #1;
        checks++;
        if (dep !== 1'b0) begin errors++; $display("FAIL rst_br_cnt: dep=%b expected 0", dep); end
        tick();
        checks++;
        if ({de_valid, o_s1, o_s2} !== {1'b1, 16'h0, 16'h0}) begin
            errors++; $display("FAIL rst_br_regs: valid=%b s1=%h s2=%h expected 1,0,0", de_valid, o_s1, o_s2);
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0: op = ADD;
                1: op = ADDI;
                2: op = BRZ;
                3: op = NOP;
                default: op = 8'($urandom);
            endcase
            drive($urandom_range(0, 7) != 0, mk(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  4'($urandom_range(0, 3)), 16'($urandom));
            lock = $urandom_range(0, 11) != 0;
            rst  = $urandom_range(0, 79) == 0;
            #1;
            checks++;
            if (dep !== exp_dep()) begin errors++; $display("FAIL rnd_dep[%0d]: got %b expected %b", n, dep, exp_dep()); end
            tick();
            checks++;
            if ({de_valid, brstall, o_op, o_dest, o_pc, o_s1, o_s2, o_imm} !== {m_valid, m_br, m_op, m_dest, m_pc, m_s1, m_s2, m_imm}) begin
                errors++;
                $display("FAIL rnd_out[%0d]: got v=%b br=%b op=%h d=%h pc=%h s1=%h s2=%h imm=%h expected v=%b br=%b op=%h d=%h pc=%h s1=%h s2=%h imm=%h",
                         n, de_valid, brstall, o_op, o_dest, o_pc, o_s1, o_s2, o_imm, m_valid, m_br, m_op, m_dest, m_pc, m_s1, m_s2, m_imm);
            end
        end
        rst = 0; lock = 1;
    endtask

    initial begin
        rst = 1; lock = 1;
        drive(0, mk(NOP, 0, 0, 0));
        test_reset();
        test_issue();
        test_dependency();
        test_saturation();
        test_branch();
        test_gpu_stall();
        test_reset_in_branch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
